jellyvl_etherneco_synctimer_slave_rx: RTL

- Parametrised second-generation EtherNeCo sync-timer slave front end. Parses the sync command frame: command byte, TIME_BYTES-byte master time, then one OFFSET_BYTES-byte offset per node.
- Issues a checked correction request (time plus this node's offset) to an external synctimer core.
- Measures command-to-response turnaround and inserts it into this node's slot of the response frame.
- Adds over the previous slave: configurable field widths, frame-completeness checking, node-0 bypass, an armed/valid response, and a drop counter.

---
 rtl/jellyvl_etherneco_synctimer_slave_rx.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/jellyvl_etherneco_synctimer_slave_rx.sv
// EtherNeCo sync-timer slave receive front end: parses the sync command frame into a
// checked correction request and patches the measured turnaround into the response frame.
module jellyvl_etherneco_synctimer_slave_rx #(
    parameter int TIMER_WIDTH   = 64,
    parameter int TIME_BYTES    = 8,
    parameter int OFFSET_BYTES  = 4,
    parameter int ELAPSED_BYTES = 4,
    parameter int DROP_WIDTH    = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [TIMER_WIDTH-1:0]     current_time,

    input  logic                       cmd_rx_start,
    input  logic                       cmd_rx_end,
    input  logic                       cmd_rx_error,
    input  logic [7:0]                 cmd_rx_node,
    input  logic                       s_cmd_first,
    input  logic [15:0]                s_cmd_pos,
    input  logic [7:0]                 s_cmd_data,
    input  logic                       s_cmd_valid,

    input  logic                       res_rx_start,
    input  logic                       res_rx_error,
    input  logic [15:0]                s_res_pos,
    input  logic                       s_res_valid,
    output logic [7:0]                 m_res_data,
    output logic                       m_res_valid,

    output logic [TIMER_WIDTH-1:0]     correct_time,
    output logic                       correct_override,
    output logic                       correct_valid,
    output logic [ELAPSED_BYTES*8-1:0] elapsed_time,
    output logic [DROP_WIDTH-1:0]      drop_count
);

    localparam int TW = TIME_BYTES * 8;
    localparam int OW = OFFSET_BYTES * 8;
    localparam int EW = ELAPSED_BYTES * 8;

    typedef enum logic {
        IDLE,
        CMD
    } state_t;

    state_t          state;
    logic [1:0]      cmd_bits;
    logic [TW-1:0]   time_data;
    logic [OW-1:0]   offset_data;
    logic [15:0]     time_cnt;
    logic [15:0]     off_cnt;
    logic [EW-1:0]   start_time;
    logic            resp_armed;
    logic            resp_valid;

    logic            node_zero;
    logic            time_hit;
    logic            off_hit;
    logic            res_hit;
    logic            accept;
    int              time_idx;
    int              off_idx;
    int              res_idx;
    logic [OW-1:0]   offset_eff;
    logic [EW-1:0]   now_low;
    logic            unused_bits;

    assign unused_bits = ^current_time;

    // Byte-position decode for the command and response frames of this node.
    always_comb begin
        node_zero  = (cmd_rx_node == 8'd0);
        time_idx   = int'(s_cmd_pos) - 1;
        time_hit   = (time_idx >= 0) && (time_idx < TIME_BYTES);
        off_idx    = int'(s_cmd_pos) - (1 + TIME_BYTES + OFFSET_BYTES * (int'(cmd_rx_node) - 1));
        off_hit    = !node_zero && (off_idx >= 0) && (off_idx < OFFSET_BYTES);
        res_idx    = int'(s_res_pos) - (1 + TIME_BYTES + ELAPSED_BYTES * (int'(cmd_rx_node) - 1));
        res_hit    = !node_zero && (res_idx >= 0) && (res_idx < ELAPSED_BYTES);
        accept     = node_zero || ((time_cnt == 16'(TIME_BYTES)) && (off_cnt == 16'(OFFSET_BYTES)));
        offset_eff = node_zero ? '0 : offset_data;
        now_low    = EW'(current_time);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            cmd_bits         <= '0;
            time_data        <= '0;
            offset_data      <= '0;
            time_cnt         <= '0;
            off_cnt          <= '0;
            correct_time     <= '0;
            correct_override <= 1'b0;
            correct_valid    <= 1'b0;
            drop_count       <= '0;
        end else begin
            correct_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (s_cmd_valid && s_cmd_first && !cmd_rx_error && !cmd_rx_end) begin
                        state       <= CMD;
                        cmd_bits    <= s_cmd_data[1:0];
                        time_data   <= '0;
                        offset_data <= '0;
                        time_cnt    <= '0;
                        off_cnt     <= '0;
                    end
                end
                CMD: begin
                    // Error beats end: a simultaneous end still counts as a lost request.
                    if (cmd_rx_error) begin
                        state <= IDLE;
                        if (cmd_rx_end && cmd_bits[0] && (drop_count != {DROP_WIDTH{1'b1}})) begin
                            drop_count <= drop_count + 1'b1;
                        end
                    end else if (cmd_rx_end) begin
                        state <= IDLE;
                        if (cmd_bits[0]) begin
                            if (accept) begin
                                correct_valid    <= 1'b1;
                                correct_override <= cmd_bits[1];
                                correct_time     <= TIMER_WIDTH'(time_data) + TIMER_WIDTH'(offset_eff);
                            end else if (drop_count != {DROP_WIDTH{1'b1}}) begin
                                drop_count <= drop_count + 1'b1;
                            end
                        end
                    end else if (s_cmd_valid) begin
                        if (s_cmd_first) begin
                            cmd_bits    <= s_cmd_data[1:0];
                            time_data   <= '0;
                            offset_data <= '0;
                            time_cnt    <= '0;
                            off_cnt     <= '0;
                        end else begin
                            if (time_hit) begin
                                time_data[time_idx*8 +: 8] <= s_cmd_data;
                                time_cnt                   <= time_cnt + 16'd1;
                            end
                            if (off_hit) begin
                                offset_data[off_idx*8 +: 8] <= s_cmd_data;
                                off_cnt                     <= off_cnt + 16'd1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Turnaround measurement; a coincident command start re-arms after the old start is consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_time   <= '0;
            resp_armed   <= 1'b0;
            resp_valid   <= 1'b0;
            elapsed_time <= '0;
        end else begin
            if (res_rx_start) begin
                if (resp_armed) begin
                    elapsed_time <= now_low - start_time;
                    resp_armed   <= 1'b0;
                    resp_valid   <= 1'b1;
                end else begin
                    resp_valid <= 1'b0;
                end
            end
            if (cmd_rx_start) begin
                start_time <= now_low;
                resp_armed <= 1'b1;
            end
            if (res_rx_error) begin
                resp_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_res_valid <= 1'b0;
            m_res_data  <= '0;
        end else if (!res_rx_error && s_res_valid && resp_valid && res_hit) begin
            m_res_valid <= 1'b1;
            m_res_data  <= elapsed_time[res_idx*8 +: 8];
        end else begin
            m_res_valid <= 1'b0;
            m_res_data  <= '0;
        end
    end

endmodule
